// File: rtl/game_over_overlay_ctrl_if.sv
// ============================================================================
// Module      : game_over_overlay_ctrl_if
// Description : Restart request/acknowledge handshake between the game-over
//               overlay sequencer (master) and game logic (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_over_overlay_ctrl_if;
  logic restart_req;
  logic restart_ack;

  modport master (
    output restart_req,
    input  restart_ack
  );

  modport slave (
    input  restart_req,
    output restart_ack
  );
endinterface

`default_nettype wire

// File: rtl/game_over_overlay_ctrl.sv
// ============================================================================
// Module      : game_over_overlay_ctrl
// Description : "GAME OVER" overlay sequencer. Reveals the text row by row,
//               optionally blinks it, enforces a minimum display time, then
//               raises a restart request and waits for game logic to ack.
//               Optional feature macro: GAME_OVER_BLINK_EN (blink in SHOW).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_over_overlay_ctrl #(
  parameter int MSG_Y           = 180,
  parameter int TEXT_H          = 11,
  parameter int SCALE           = 3,
  parameter int REVEAL_FRAMES   = 4,
  parameter int BLINK_FRAMES    = 30,
  parameter int MIN_HOLD_FRAMES = 60
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  frame_tick,
  input  wire logic                  game_over,
  input  wire logic [9:0]            Y,
  input  wire logic                  rom_inside,
  input  wire logic                  rom_pixel,
  input  wire logic                  restart_btn,
  game_over_overlay_ctrl_if.master   rif,
  output logic                       text_pixel,
  output logic                       busy,
  output logic [1:0]                 state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REVEAL = 2'd1,
    S_SHOW   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam logic [7:0] c_reveal_last = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0] c_min_hold    = 8'(MIN_HOLD_FRAMES);
  localparam logic [3:0] c_text_h      = 4'(TEXT_H);
  localparam logic [9:0] c_msg_y       = 10'(MSG_Y);
  localparam logic [9:0] c_scale       = 10'(SCALE);
`ifdef GAME_OVER_BLINK_EN
  localparam logic [7:0] c_blink_last  = 8'(BLINK_FRAMES - 1);
`endif

  state_t     r_state;
  logic       r_go_cur;
  logic       r_go_prev;
  logic       r_btn_cur;
  logic       r_btn_prev;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_hold_cnt;
  logic [3:0] r_reveal_rows;
  logic       r_blink_phase;
  logic       r_restart_req;
  logic       r_text_pixel;

  logic       w_go_rise;
  logic       w_btn_rise;
  logic [3:0] w_reveal_next;
  logic [9:0] w_dy;
  logic [9:0] w_reveal_limit;
  logic       w_visible;

  // Rises are judged on the registered copies so both inputs see one extra
  // cycle of latency before the FSM reacts.
  assign w_go_rise     = r_go_cur  & ~r_go_prev;
  assign w_btn_rise    = r_btn_cur & ~r_btn_prev;
  assign w_reveal_next = r_reveal_rows + 4'd1;

  // Row offset into the overlay; lines above MSG_Y wrap to large values and
  // therefore never fall inside the revealed band.
  assign w_dy           = Y - c_msg_y;
  assign w_reveal_limit = {6'd0, r_reveal_rows} * c_scale;

  // Edge-detect registers for game_over and restart_btn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_go_cur   <= 1'b0;
      r_go_prev  <= 1'b0;
      r_btn_cur  <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_go_cur   <= game_over;
      r_go_prev  <= r_go_cur;
      r_btn_cur  <= restart_btn;
      r_btn_prev <= r_btn_cur;
    end
  end

  // Overlay sequencer: reveal, show/blink with minimum hold, restart handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= 8'd0;
      r_hold_cnt    <= 8'd0;
      r_reveal_rows <= 4'd0;
      r_blink_phase <= 1'b0;
      r_restart_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go_rise) begin
            r_state       <= S_REVEAL;
            r_frame_cnt   <= 8'd0;
            r_hold_cnt    <= 8'd0;
            r_reveal_rows <= 4'd0;
            r_blink_phase <= 1'b0;
          end
        end

        S_REVEAL: begin
          // Dropping game_over takes priority over any frame tick.
          if (!game_over) begin
            r_state <= S_IDLE;
          end else if (frame_tick) begin
            if (r_frame_cnt == c_reveal_last) begin
              r_frame_cnt   <= 8'd0;
              r_reveal_rows <= w_reveal_next;
              if (w_reveal_next == c_text_h) begin
                r_state <= S_SHOW;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end

        S_SHOW: begin
          if (!game_over) begin
            r_state <= S_IDLE;
          end else begin
            if (frame_tick) begin
              if (r_hold_cnt < c_min_hold) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
              end
`ifdef GAME_OVER_BLINK_EN
              if (r_frame_cnt == c_blink_last) begin
                r_frame_cnt   <= 8'd0;
                r_blink_phase <= ~r_blink_phase;
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
`endif
            end
            // Qualified against the pre-tick hold count; early presses are
            // simply dropped.
            if (w_btn_rise && (r_hold_cnt == c_min_hold)) begin
              r_state       <= S_ACK;
              r_restart_req <= 1'b1;
            end
          end
        end

        S_ACK: begin
          if (rif.restart_ack) begin
            r_state       <= S_IDLE;
            r_restart_req <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Per-state visibility of the overlay text.
  always_comb begin
    w_visible = 1'b0;
    case (r_state)
      S_IDLE:   w_visible = 1'b0;
      S_REVEAL: w_visible = (w_dy < w_reveal_limit);
      S_SHOW:   w_visible = ~r_blink_phase;
      S_ACK:    w_visible = 1'b1;
      default:  w_visible = 1'b0;
    endcase
  end

  // Registered overlay pixel, one clock behind the scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_text_pixel <= 1'b0;
    end else begin
      r_text_pixel <= rom_inside & rom_pixel & w_visible;
    end
  end

  assign text_pixel      = r_text_pixel;
  assign busy            = (r_state != S_IDLE);
  assign state           = r_state;
  assign rif.restart_req = r_restart_req;

endmodule

`default_nettype wire

// File: tb/tb_game_over_overlay_ctrl.sv
// ============================================================================
// Module      : tb_game_over_overlay_ctrl
// Description : Self-checking bench for game_over_overlay_ctrl. Expected
//               text_pixel values are queued as stimulus is driven and
//               compared one clock later; scenario tasks check state,
//               busy and the restart handshake inline.
//               Honours GAME_OVER_BLINK_EN for the blink expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_over_overlay_ctrl;

  localparam int MSG_Y           = 180;
  localparam int TEXT_H          = 11;
  localparam int SCALE           = 3;
  localparam int REVEAL_FRAMES   = 2;
  localparam int BLINK_FRAMES    = 3;
  localparam int MIN_HOLD_FRAMES = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       game_over;
  logic [9:0] Y;
  logic       rom_inside;
  logic       rom_pixel;
  logic       restart_btn;
  logic       text_pixel;
  logic       busy;
  logic [1:0] state;

  game_over_overlay_ctrl_if rif();

  game_over_overlay_ctrl #(
    .MSG_Y           (MSG_Y),
    .TEXT_H          (TEXT_H),
    .SCALE           (SCALE),
    .REVEAL_FRAMES   (REVEAL_FRAMES),
    .BLINK_FRAMES    (BLINK_FRAMES),
    .MIN_HOLD_FRAMES (MIN_HOLD_FRAMES)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .game_over   (game_over),
    .Y           (Y),
    .rom_inside  (rom_inside),
    .rom_pixel   (rom_pixel),
    .restart_btn (restart_btn),
    .rif         (rif),
    .text_pixel  (text_pixel),
    .busy        (busy),
    .state       (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected text_pixel values, one per driven cycle.
  bit exp_q[$];
  bit e_sb;

  // Reference model of the sequencer as seen from outside.
  int m_state;
  int m_rows;
  int m_fc;
  int m_hold;
  bit m_blink;

  function automatic bit model_vis(input logic [9:0] y);
    logic [9:0] dy;
    logic [9:0] lim;
    dy  = y - 10'(MSG_Y);
    lim = 10'(m_rows * SCALE);
    case (m_state)
      1:       return (dy < lim);
      2:       return !m_blink;
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_start_reveal();
    m_state = 1;
    m_rows  = 0;
    m_fc    = 0;
    m_hold  = 0;
    m_blink = 1'b0;
  endtask

  task automatic model_tick();
    if (m_state == 1) begin
      if (m_fc == REVEAL_FRAMES - 1) begin
        m_fc = 0;
        m_rows++;
        if (m_rows == TEXT_H) m_state = 2;
      end else begin
        m_fc++;
      end
    end else if (m_state == 2) begin
      if (m_hold < MIN_HOLD_FRAMES) m_hold++;
`ifdef GAME_OVER_BLINK_EN
      if (m_fc == BLINK_FRAMES - 1) begin
        m_fc    = 0;
        m_blink = !m_blink;
      end else begin
        m_fc++;
      end
`endif
    end
  endtask

  // Queue the expectation for the inputs currently driven, advance one clock.
  task automatic step();
    exp_q.push_back(rom_inside & rom_pixel & model_vis(Y));
    @(negedge clk);
  endtask

  // One frame: a tick cycle followed by nine scan-line probes.
  task automatic do_tick();
    int off;
    frame_tick = 1'b1;
    rom_inside = 1'b0;
    rom_pixel  = 1'b1;
    Y          = 10'(MSG_Y);
    step();
    frame_tick = 1'b0;
    model_tick();
    off = (m_rows >= 7) ? 3 : 0;
    for (int c = 0; c < 9; c++) begin
      Y          = 10'(MSG_Y + SCALE * (c + off) + (c % SCALE));
      rom_inside = 1'b1;
      rom_pixel  = (c != 7);
      if (c == 8) Y = 10'(MSG_Y - 10);
      step();
    end
    rom_inside = 1'b0;
  endtask

  // Pixel scoreboard monitor, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_sb = exp_q.pop_front();
      checks++;
      if (text_pixel !== e_sb) begin
        errors++;
        $display("FAIL pixel_sb t=%0t text_pixel=%b expected=%b", $time, text_pixel, e_sb);
      end
    end
  end

  task automatic test_reset();
    rst_n           = 1'b0;
    frame_tick      = 1'b0;
    game_over       = 1'b0;
    Y               = 10'd0;
    rom_inside      = 1'b0;
    rom_pixel       = 1'b0;
    restart_btn     = 1'b0;
    rif.restart_ack = 1'b0;
    m_state = 0; m_rows = 0; m_fc = 0; m_hold = 0; m_blink = 1'b0;
    repeat (3) step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rif.restart_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", rif.restart_req); end
    checks++; if (text_pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel got=%b exp=0", text_pixel); end
    rst_n = 1'b1;
    repeat (2) step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_reset_state got=%0d exp=0", state); end
  endtask

  task automatic test_reveal();
    game_over = 1'b1;
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL go_latency1 got=%0d exp=0", state); end
    step();
    model_start_reveal();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL go_latency2 got=%0d exp=1", state); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reveal_busy got=%b exp=1", busy); end
    for (int i = 0; i < 22; i++) begin
      do_tick();
      if (i == 20) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL reveal_21_ticks got=%0d exp=1", state); end
      end
    end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL reveal_to_show got=%0d exp=2", state); end
  endtask

  task automatic test_blink();
    bit exp_tp;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      Y          = 10'(MSG_Y + 4);
      rom_inside = 1'b1;
      rom_pixel  = 1'b1;
      step();
`ifdef GAME_OVER_BLINK_EN
      exp_tp = (i < 2);
`else
      exp_tp = 1'b1;
`endif
      checks++;
      if (text_pixel !== exp_tp) begin
        errors++;
        $display("FAIL blink_tick%0d got=%b exp=%b", i + 1, text_pixel, exp_tp);
      end
      rom_inside = 1'b0;
    end
  endtask

  task automatic test_hold();
    // hold_cnt is 3 here
    rif.restart_ack = 1'b1;
    step();
    rif.restart_ack = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL ack_outside_ack got=%0d exp=2", state); end
    restart_btn = 1'b1;
    step();
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL early_press_state got=%0d exp=2", state); end
    checks++; if (rif.restart_req !== 1'b0) begin errors++; $display("FAIL early_press_req got=%b exp=0", rif.restart_req); end
    restart_btn = 1'b0;
    step();
    step();
    do_tick();
    // hold_cnt is 4: a rise coinciding with the 5th tick still sees 4
    restart_btn = 1'b1;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    model_tick();
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL press_with_tick got=%0d exp=2", state); end
    restart_btn = 1'b0;
    step();
    step();
    // hold_cnt is 5: accepted
    restart_btn = 1'b1;
    step();
    checks++; if (rif.restart_req !== 1'b0) begin errors++; $display("FAIL req_edge1 got=%b exp=0", rif.restart_req); end
    step();
    m_state = 3;
    checks++; if (rif.restart_req !== 1'b1) begin errors++; $display("FAIL req_edge2 got=%b exp=1", rif.restart_req); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL ack_state got=%0d exp=3", state); end
    restart_btn = 1'b0;
    step();
    rif.restart_ack = 1'b1;
    step();
    m_state = 0;
    rif.restart_ack = 1'b0;
    checks++; if (rif.restart_req !== 1'b0) begin errors++; $display("FAIL ack_req_drop got=%b exp=0", rif.restart_req); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ack_to_idle got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ack_busy got=%b exp=0", busy); end
    repeat (3) step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_no_rise got=%0d exp=0", state); end
  endtask

  task automatic test_abort();
    game_over = 1'b0;
    step();
    step();
    game_over = 1'b1;
    step();
    step();
    model_start_reveal();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL abort_reveal_entry got=%0d exp=1", state); end
    repeat (8) do_tick();
    // reveal_rows is 4: row 4 is still hidden
    Y          = 10'(MSG_Y + 4 * SCALE);
    rom_inside = 1'b1;
    rom_pixel  = 1'b1;
    step();
    checks++; if (text_pixel !== 1'b0) begin errors++; $display("FAIL row4_hidden got=%b exp=0", text_pixel); end
    // abort coincides with a tick; row 3 is visible in the last REVEAL cycle
    Y          = 10'(MSG_Y + 3 * SCALE);
    game_over  = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    m_state    = 0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (text_pixel !== 1'b1) begin errors++; $display("FAIL abort_last_pixel got=%b exp=1", text_pixel); end
    step();
    checks++; if (text_pixel !== 1'b0) begin errors++; $display("FAIL abort_pixel_off got=%b exp=0", text_pixel); end
    rom_inside = 1'b0;
    step();
  endtask

  task automatic test_reset_in_ack();
    game_over = 1'b1;
    step();
    step();
    model_start_reveal();
    repeat (27) do_tick();
    restart_btn = 1'b1;
    step();
    step();
    m_state = 3;
    restart_btn = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL reach_ack got=%0d exp=3", state); end
    // pixel gating in ACK
    Y          = 10'(MSG_Y + 10);
    rom_inside = 1'b0;
    rom_pixel  = 1'b1;
    step();
    checks++; if (text_pixel !== 1'b0) begin errors++; $display("FAIL gate_outside got=%b exp=0", text_pixel); end
    rom_inside = 1'b1;
    step();
    checks++; if (text_pixel !== 1'b1) begin errors++; $display("FAIL gate_inside got=%b exp=1", text_pixel); end
    // asynchronous reset away from any clock edge
    #2;
    rst_n   = 1'b0;
    m_state = 0;
    #1;
    checks++; if (rif.restart_req !== 1'b0) begin errors++; $display("FAIL async_req got=%b exp=0", rif.restart_req); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state got=%0d exp=0", state); end
    checks++; if (text_pixel !== 1'b0) begin errors++; $display("FAIL async_pixel got=%b exp=0", text_pixel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", busy); end
    game_over = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_release_idle got=%0d exp=0", state); end
    game_over = 1'b1;
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rerise_edge1 got=%0d exp=0", state); end
    step();
    model_start_reveal();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rerise_edge2 got=%0d exp=1", state); end
    game_over = 1'b0;
    step();
    m_state = 0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL final_abort got=%0d exp=0", state); end
    rom_inside = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_reveal();
    test_blink();
    test_hold();
    test_abort();
    test_reset_in_ack();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_over_overlay_ctrl.md
# game_over_overlay_ctrl

Sequencer for the "GAME OVER" text overlay. It sits between game logic and the game-over text bitmap ROM, and consumes the ROM's `inside_area`/`is_pixel` outputs for the current scan position. It reveals the text row by row, blinks it, enforces a minimum display time, then hands a restart request back to game logic over a req/ack handshake. Its registered `text_pixel` output feeds the VGA colour mux.

## Interface
- `MSG_Y`, 180, top scan line of the overlay; must match the ROM placement.
- `TEXT_H`, 11, bitmap rows; range 1..15.
- `SCALE`, 3, scan lines per bitmap row.
- `REVEAL_FRAMES`, 4, frames per revealed row; range 1..255.
- `BLINK_FRAMES`, 30, frames per blink half-period; range 1..255.
- `MIN_HOLD_FRAMES`, 60, frames in SHOW before restart is accepted; range 0..255.

- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, from vsync.
- `game_over` in 1: level from game logic.
- `Y` in 10: current scan line.
- `rom_inside` in 1: ROM `inside_area` for the current X/Y.
- `rom_pixel` in 1: ROM `is_pixel` for the current X/Y.
- `restart_btn` in 1: already-synchronised button level.
- `restart_ack` in 1: game logic acknowledge.
- `restart_req` out 1: restart request, held until acknowledged.
- `text_pixel` out 1: registered overlay pixel.
- `busy` out 1: high whenever state ≠ IDLE.
- `state` out 2: IDLE=0, REVEAL=1, SHOW=2, ACK=3.

## Operation
- Edge detection: `game_over` and `restart_btn` are each registered once. A rise is current=1 with previous=0.
- Counters: `frame_cnt` 8-bit, `hold_cnt` 8-bit (saturating), `reveal_rows` 4-bit, `blink_phase` 1-bit.
- IDLE: on a `game_over` rise, go to REVEAL and clear all counters.
- REVEAL: each `frame_tick` increments `frame_cnt`.
  - A tick with `frame_cnt==REVEAL_FRAMES-1` instead clears `frame_cnt` and increments `reveal_rows`.
  - When `reveal_rows` becomes TEXT_H, go to SHOW on the same edge and clear `frame_cnt`.
- SHOW: each tick increments `hold_cnt`, saturating at MIN_HOLD_FRAMES.
  - Blink: each tick increments `frame_cnt`. A tick with `frame_cnt==BLINK_FRAMES-1` clears it and toggles `blink_phase`.
  - A `restart_btn` rise with `hold_cnt==MIN_HOLD_FRAMES` goes to ACK. Earlier rises are ignored, not queued.
- ACK: `restart_req`=1. The cycle `restart_ack`=1 is sampled, go to IDLE; `restart_req` deasserts on that edge.
- Abort: `game_over`=0 in REVEAL or SHOW forces IDLE next edge. ACK ignores `game_over`.
- Visibility by state:
  - IDLE: 0.
  - REVEAL: (Y−MSG_Y) < `reveal_rows`·SCALE, computed in 10 bits and valid only when `rom_inside`=1.
  - SHOW: `blink_phase`==0.
  - ACK: 1.
- Pixel rule: `text_pixel` next = `rom_inside` & `rom_pixel` & visible.

## Timing
- Reset values: state=IDLE, `restart_req`=0, `text_pixel`=0, `busy`=0, all counters and edge registers 0.
- Latency:
  - `text_pixel` lags `Y`/`rom_*` by exactly 1 clk.
  - IDLE→REVEAL occurs 2 edges after `game_over` rises, because of the edge register.
- Transitions:
  - REVEAL lasts TEXT_H·REVEAL_FRAMES ticks.
  - SHOW→ACK occurs 2 edges after a qualifying button rise.
  - ACK→IDLE occurs 1 edge after `restart_ack` is sampled.
- Simultaneous events:
  - A tick and a button rise on the same edge: the button is qualified against the pre-tick `hold_cnt`.
  - Abort and a tick on the same edge: abort wins.
- `restart_ack` outside ACK is ignored.
- `rst_n` low at any point returns all outputs to reset values immediately, asynchronously; `restart_req` drops without waiting for ack.
- With MIN_HOLD_FRAMES=0, a button rise is accepted from the first SHOW cycle.

## Configuration
- `GAME_OVER_BLINK_EN` defined: SHOW blinks as described.
- `GAME_OVER_BLINK_EN` undefined: `blink_phase` is held 0, so text is steady in SHOW, and the blink comparison logic is absent. All other behaviour is unchanged.

## Test plan
Bench parameters: REVEAL_FRAMES=2, BLINK_FRAMES=3, MIN_HOLD_FRAMES=5, tick every 10 clk.
- Reveal: raise `game_over`, sample `Y`=180+3·k with `rom_inside`=`rom_pixel`=1 → `text_pixel`=1 only for k<`reveal_rows`; state=2 after 22 ticks.
- Blink (macro defined): in SHOW → `text_pixel` toggles every 3 ticks. Macro undefined → `text_pixel` stays 1 throughout SHOW.
- Hold: press at `hold_cnt`=3 → ignored, state stays 2. Press after 5 ticks → `restart_req`=1 2 clk later. Ack → `restart_req`=0 and state=0 next edge.
- Abort: drop `game_over` mid-REVEAL (`reveal_rows`=4) → state=0, `busy`=0 next edge, `text_pixel`=0 one clk later.
- Reset: assert `rst_n`=0 in ACK → `restart_req`=0 and state=0 without a clock edge. Release → stays IDLE until the next `game_over` rise.
- Pixel gating: `rom_inside`=0, `rom_pixel`=1 in ACK → `text_pixel`=0. `rom_inside`=1, `rom_pixel`=1 → `text_pixel`=1 exactly 1 clk later.
